// File: rtl/pkt_buf_ctrl.sv
// pkt_buf_ctrl: circular buffer of fixed-size packet slots sequencing a dual-port RAM between a write and a read stream
module pkt_buf_ctrl #(
    parameter int BUS_WIDTH  = 32,
    parameter int SLOT_BEATS = 16,
    parameter int NUM_SLOTS  = 100,
    parameter int RD_LAT     = 1
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           wr_valid,
    input  logic [BUS_WIDTH-1:0]           wr_data,
    input  logic                           wr_last,
    output logic                           wr_ready,
    output logic                           rd_valid,
    output logic [BUS_WIDTH-1:0]           rd_data,
    output logic                           rd_last,
    input  logic                           rd_ready,
    output logic                           mem_ena,
    output logic [3:0]                     mem_wea,
    output logic [31:0]                    mem_addra,
    output logic [BUS_WIDTH-1:0]           mem_dina,
    output logic                           mem_enb,
    output logic [31:0]                    mem_addrb,
    input  logic [BUS_WIDTH-1:0]           mem_doutb,
    input  logic                           mem_busy,
    output logic [$clog2(NUM_SLOTS+1)-1:0] pkt_count,
    output logic [15:0]                    drop_cnt
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int BW = $clog2(SLOT_BEATS);
    localparam int LW = $clog2(SLOT_BEATS + 1);
    localparam int CW = $clog2(NUM_SLOTS + 1);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_HOLD} rstate_t;

    rstate_t        state;
    logic [SW-1:0]  wr_slot, rd_slot;
    logic [BW-1:0]  wr_beat, rd_beat;
    logic [LW-1:0]  len [NUM_SLOTS];
    logic [1:0]     wcnt;
    logic           dropping, accept, commit, pop;

    function automatic logic [31:0] slot_addr(input logic [SW-1:0] s, input logic [BW-1:0] b);
        return 32'(s) * 32'(SLOT_BEATS) + 32'(b);
    endfunction

    function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] s);
        return s == SW'(NUM_SLOTS - 1) ? '0 : s + SW'(1);
    endfunction

    // wr_ready is forced low while reset is held so the write port is quiet during reset
    always_comb begin
        wr_ready  = reset && (pkt_count < CW'(NUM_SLOTS)) && !mem_busy;
        accept    = wr_valid && wr_ready;
        mem_ena   = accept && !dropping;
        mem_wea   = mem_ena ? 4'hF : 4'h0;
        mem_addra = slot_addr(wr_slot, wr_beat);
        mem_dina  = wr_data;
        commit    = mem_ena && wr_last;
        pop       = state == R_HOLD && rd_valid && rd_ready && rd_last;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_slot  <= '0;
            wr_beat  <= '0;
            dropping <= 1'b0;
            drop_cnt <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) len[i] <= '0;
        end else if (accept) begin
            if (dropping) begin
                if (wr_last) begin
                    dropping <= 1'b0;
                    wr_beat  <= '0;
                    drop_cnt <= drop_cnt + 16'(drop_cnt != 16'hFFFF);
                end
            end else if (wr_last) begin
                len[wr_slot] <= LW'(wr_beat) + LW'(1);
                wr_slot      <= next_slot(wr_slot);
                wr_beat      <= '0;
            end else if (wr_beat == BW'(SLOT_BEATS - 1)) begin
                dropping <= 1'b1;
                wr_beat  <= '0;
            end else begin
                wr_beat <= wr_beat + BW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= R_IDLE;
            rd_slot   <= '0;
            rd_beat   <= '0;
            wcnt      <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
            mem_enb   <= 1'b0;
            mem_addrb <= '0;
            pkt_count <= '0;
        end else begin
            pkt_count <= pkt_count + CW'(commit) - CW'(pop);
            case (state)
                R_IDLE: if (pkt_count != '0 && !mem_busy) begin
                    state     <= R_ADDR;
                    mem_enb   <= 1'b1;
                    mem_addrb <= slot_addr(rd_slot, rd_beat);
                end
                R_ADDR: begin
                    state   <= R_WAIT;
                    mem_enb <= 1'b0;
                    wcnt    <= 2'(RD_LAT);
                end
                R_WAIT: begin
                    wcnt <= wcnt - 2'd1;
                    if (wcnt == 2'd1) begin
                        state    <= R_HOLD;
                        rd_valid <= 1'b1;
                        rd_data  <= mem_doutb;
                        rd_last  <= LW'(rd_beat) == len[rd_slot] - LW'(1);
                    end
                end
                R_HOLD: if (rd_ready) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                    if (rd_last) begin
                        rd_slot <= next_slot(rd_slot);
                        rd_beat <= '0;
                        state   <= R_IDLE;
                    end else begin
                        rd_beat   <= rd_beat + BW'(1);
                        state     <= mem_busy ? R_IDLE : R_ADDR;
                        mem_enb   <= !mem_busy;
                        mem_addrb <= slot_addr(rd_slot, rd_beat + BW'(1));
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// tb_pkt_buf_ctrl: randomized scenarios checked against a packet-level queue model of the slot buffer
module tb_pkt_buf_ctrl;
    logic        CLK = 1'b0, reset = 1'b0;
    logic        wr_valid = 1'b0, wr_last = 1'b0, rd_ready = 1'b0, mem_busy = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready, rd_valid, rd_last, mem_ena, mem_enb;
    logic [31:0] rd_data, mem_addra, mem_dina, mem_addrb, mem_doutb;
    logic [3:0]  mem_wea;
    logic [6:0]  pkt_count;
    logic [15:0] drop_cnt;
    logic [31:0] ram [2048];

    int total = 0, bad = 0;
    logic [31:0] tx_d[$], sb_d[$], cur[$];
    bit          tx_l[$], sb_l[$];
    int m_count = 0, m_slot = 0, m_idx = 0, m_drops = 0, busy_left = 0;
    bit prev_busy = 0, prev_hold = 0;
    logic [31:0] prev_data = '0;

    pkt_buf_ctrl dut (
        .CLK(CLK), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .rd_ready(rd_ready), .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
        .mem_dina(mem_dina), .mem_enb(mem_enb), .mem_addrb(mem_addrb), .mem_doutb(mem_doutb),
        .mem_busy(mem_busy), .pkt_count(pkt_count), .drop_cnt(drop_cnt)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_ena && mem_wea == 4'hF) ram[mem_addra[10:0]] <= mem_dina;
        if (mem_enb) mem_doutb <= ram[mem_addrb[10:0]];
    end

    task automatic push_pkt(input int n);
        for (int i = 0; i < n; i++) begin
            tx_d.push_back($urandom);
            tx_l.push_back(i == n - 1);
        end
    endtask

    task automatic model_reset();
        tx_d.delete(); tx_l.delete(); sb_d.delete(); sb_l.delete(); cur.delete();
        m_count = 0; m_slot = 0; m_idx = 0; m_drops = 0; busy_left = 0;
        prev_busy = 0; prev_hold = 0;
    endtask

    // One clock of traffic: drive, compare every observable against the model, then advance the model
    task automatic cycle(input int vp, input int rp);
        bit exp_rdy, acc, lst;
        @(negedge CLK);
        mem_busy = busy_left > 0;
        if (busy_left > 0) busy_left--;
        wr_valid = tx_d.size() > 0 && $urandom_range(99) < vp;
        wr_data  = wr_valid ? tx_d[0] : $urandom;
        wr_last  = wr_valid ? tx_l[0] : 1'b0;
        rd_ready = $urandom_range(99) < rp;
        #1;
        exp_rdy = m_count < 100 && !mem_busy;
        total++;
        if (wr_ready !== exp_rdy) begin bad++; $display("FAIL wr_ready got=%b exp=%b", wr_ready, exp_rdy); end
        total++;
        if (pkt_count !== 7'(m_count)) begin bad++; $display("FAIL pkt_count got=%0d exp=%0d", pkt_count, m_count); end
        total++;
        if (drop_cnt !== 16'(m_drops)) begin bad++; $display("FAIL drop_cnt got=%0d exp=%0d", drop_cnt, m_drops); end
        if (prev_busy && mem_busy) begin
            total++;
            if (mem_enb !== 1'b0) begin bad++; $display("FAIL busy_enb got=%b exp=0", mem_enb); end
        end
        if (prev_hold) begin
            total++;
            if (rd_valid !== 1'b1 || rd_data !== prev_data)
                begin bad++; $display("FAIL hold got=%b/%h exp=1/%h", rd_valid, rd_data, prev_data); end
        end
        acc = wr_valid && exp_rdy;
        total++;
        if (acc && m_idx < 16) begin
            if (mem_ena !== 1'b1 || mem_wea !== 4'hF || mem_addra !== 32'(m_slot * 16 + m_idx) || mem_dina !== wr_data)
                begin bad++; $display("FAIL write got=%b/%h/%0d exp=1/f/%0d", mem_ena, mem_wea, mem_addra, m_slot * 16 + m_idx); end
        end else if (mem_ena !== 1'b0 || mem_wea !== 4'h0) begin
            bad++; $display("FAIL no_write got=%b/%h exp=0/0", mem_ena, mem_wea);
        end
        if (rd_valid === 1'b1 && rd_ready) begin
            total++;
            if (sb_d.size() == 0) begin
                bad++; $display("FAIL extra_beat got=%h exp=none", rd_data);
            end else begin
                if (rd_data !== sb_d[0] || rd_last !== sb_l[0])
                    begin bad++; $display("FAIL rd_beat got=%h/%b exp=%h/%b", rd_data, rd_last, sb_d[0], sb_l[0]); end
                lst = sb_l.pop_front();
                void'(sb_d.pop_front());
                if (lst) m_count--;
            end
        end
        prev_hold = rd_valid === 1'b1 && !rd_ready;
        prev_data = rd_data;
        prev_busy = mem_busy;
        if (acc) begin
            void'(tx_d.pop_front());
            void'(tx_l.pop_front());
            if (m_idx < 16) cur.push_back(wr_data);
            if (wr_last) begin
                if (m_idx < 16) begin
                    for (int i = 0; i < cur.size(); i++) begin
                        sb_d.push_back(cur[i]);
                        sb_l.push_back(i == cur.size() - 1);
                    end
                    m_count++;
                    m_slot = (m_slot + 1) % 100;
                end else if (m_drops < 65535) m_drops++;
                m_idx = 0;
                cur.delete();
            end else m_idx++;
        end
    endtask

    task automatic send_all(input int vp, input int rp);
        int n;
        for (n = 0; tx_d.size() > 0 && n < 20000; n++) cycle(vp, rp);
        if (n == 20000) begin total++; bad++; $display("FAIL send_timeout got=%0d exp=0", tx_d.size()); end
    endtask

    task automatic drain();
        int n;
        for (n = 0; (tx_d.size() > 0 || sb_d.size() > 0) && n < 20000; n++) cycle(100, 100);
        if (n == 20000) begin total++; bad++; $display("FAIL drain_timeout got=%0d exp=0", sb_d.size()); end
        cycle(0, 100);
        total++;
        if (pkt_count !== 7'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", pkt_count); end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({rd_valid, rd_last, mem_enb, mem_ena, wr_ready} !== 5'b0 || rd_data !== 0 || mem_addrb !== 0 ||
            pkt_count !== 0 || drop_cnt !== 0 || mem_wea !== 0)
            begin bad++; $display("FAIL reset_state got=%b%b%b%b%b %h %h %0d %0d", rd_valid, rd_last, mem_enb, mem_ena, wr_ready, rd_data, mem_addrb, pkt_count, drop_cnt); end
        @(negedge CLK);
        reset = 1'b1;
        #1;
        total++;
        if (wr_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b exp=1", wr_ready); end
    endtask

    task automatic test_basic();
        tx_d = '{32'hA0, 32'hA1, 32'hA2};
        tx_l = '{0, 0, 1};
        send_all(100, 0);
        cycle(0, 0);
        total++;
        if (pkt_count !== 7'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", pkt_count); end
        drain();
    endtask

    task automatic test_oversize();
        push_pkt(17);
        push_pkt(16);
        push_pkt(1);
        send_all(100, 0);
        cycle(0, 0);
        total++;
        if (drop_cnt !== 16'd1 || pkt_count !== 7'd2)
            begin bad++; $display("FAIL oversize got=%0d/%0d exp=1/2", drop_cnt, pkt_count); end
        drain();
    endtask

    task automatic test_hold_commit_pop();
        int n;
        logic [31:0] d;
        push_pkt(1);
        for (n = 0; rd_valid !== 1'b1 && n < 50; n++) cycle(100, 0);
        if (n == 50) begin total++; bad++; $display("FAIL hold_timeout got=%b exp=1", rd_valid); end
        d = rd_data;
        repeat (10) begin
            cycle(0, 0);
            total++;
            if (rd_valid !== 1'b1 || rd_data !== d) begin bad++; $display("FAIL hold10 got=%b/%h exp=1/%h", rd_valid, rd_data, d); end
        end
        push_pkt(1);
        cycle(100, 100);
        cycle(0, 0);
        total++;
        if (pkt_count !== 7'd1) begin bad++; $display("FAIL commit_pop got=%0d exp=1", pkt_count); end
        drain();
    endtask

    task automatic test_busy();
        repeat (4) push_pkt(6);
        repeat (8) cycle(100, 100);
        busy_left = 5;
        repeat (5) begin
            cycle(100, 100);
            total++;
            if (wr_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", wr_ready); end
        end
        drain();
    endtask

    task automatic test_async_reset();
        int n;
        push_pkt(1);
        push_pkt(5);
        for (n = 0; !(tx_d.size() == 3 && m_idx == 2) && n < 200; n++) cycle(100, 0);
        if (n == 200) begin total++; bad++; $display("FAIL partial_timeout got=%0d exp=3", tx_d.size()); end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({rd_valid, rd_last, mem_enb, mem_ena, wr_ready} !== 5'b0 || rd_data !== 0 || mem_addrb !== 0 ||
            mem_addra !== 0 || pkt_count !== 0 || drop_cnt !== 0 || mem_wea !== 0)
            begin bad++; $display("FAIL async_reset got=%b%b%b%b%b %h %h %0d %0d", rd_valid, rd_last, mem_enb, mem_ena, wr_ready, rd_data, mem_addrb, pkt_count, drop_cnt); end
        wr_valid = 1'b0;
        model_reset();
        @(negedge CLK);
        reset = 1'b1;
        push_pkt(3);
        drain();
    endtask

    task automatic test_full();
        int n;
        repeat (101) push_pkt(1);
        for (n = 0; m_count < 100 && n < 1000; n++) cycle(100, 0);
        if (n == 1000) begin total++; bad++; $display("FAIL fill_timeout got=%0d exp=100", m_count); end
        repeat (3) cycle(100, 0);
        total++;
        if (wr_ready !== 1'b0 || pkt_count !== 7'd100) begin bad++; $display("FAIL full got=%b/%0d exp=0/100", wr_ready, pkt_count); end
        for (n = 0; m_count == 100 && n < 50; n++) cycle(0, 100);
        cycle(0, 0);
        total++;
        if (wr_ready !== 1'b1 || pkt_count !== 7'd99) begin bad++; $display("FAIL unfull got=%b/%0d exp=1/99", wr_ready, pkt_count); end
        drain();
    endtask

    task automatic test_random();
        repeat (40) push_pkt($urandom_range(99) < 20 ? $urandom_range(17, 20) : $urandom_range(1, 16));
        for (int n = 0; tx_d.size() > 0 && n < 20000; n++) begin
            if (busy_left == 0 && $urandom_range(99) < 3) busy_left = $urandom_range(1, 6);
            cycle($urandom_range(30, 100), $urandom_range(20, 100));
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_oversize();
        test_hold_commit_pop();
        test_busy();
        test_async_reset();
        test_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pkt_buf_ctrl.md
Name: pkt_buf_ctrl

Overview:
- Sequences the dual-port block RAM (`design_1_blk_mem_gen_0_0`) as a circular buffer of NUM_SLOTS fixed-size packet slots, each holding up to SLOT_BEATS bus beats.
- Accepts parser payload beats on a valid/ready write stream and drives RAM port A.
- Replays committed packets in FIFO order on a valid/ready read stream via RAM port B.
- Owns all slot bookkeeping: pointers, per-slot lengths, occupancy and oversize drops.

Parameters:
- BUS_WIDTH, 32, data beat width; equals `BUS_WIDTH.
- SLOT_BEATS, 16, maximum beats per packet slot.
- NUM_SLOTS, 100, number of slots; equals `MEM_DEPTH.
- RD_LAT, 1, RAM port B read latency in cycles (1..3).

Ports:
- CLK  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write beat valid.
- wr_data  in  BUS_WIDTH  write beat.
- wr_last  in  1  last beat of packet.
- wr_ready  out  1  write beat accepted when high with wr_valid.
- rd_valid  out  1  read beat valid.
- rd_data  out  BUS_WIDTH  read beat.
- rd_last  out  1  last beat of packet.
- rd_ready  in  1  consumer accepts beat.
- mem_ena  out  1  RAM port A enable.
- mem_wea  out  4  RAM byte write enables.
- mem_addra  out  32  RAM write address.
- mem_dina  out  BUS_WIDTH  RAM write data.
- mem_enb  out  1  RAM port B enable.
- mem_addrb  out  32  RAM read address.
- mem_doutb  in  BUS_WIDTH  RAM read data.
- mem_busy  in  1  rsta_busy OR rstb_busy.
- pkt_count  out  $clog2(NUM_SLOTS+1)  committed, unread packets.
- drop_cnt  out  16  oversize packets dropped; saturating.

Behaviour:
- Reset (reset=0, async): all pointers, counters, lengths, FSM and registered outputs clear to 0. Partial packets are discarded.
- After reset release: wr_ready = (pkt_count<NUM_SLOTS) && !mem_busy.
- Addressing: address = slot*SLOT_BEATS + beat. Slot and beat indices wrap mod NUM_SLOTS / SLOT_BEATS. Upper address bits are zero-padded to 32.
- Write path (combinational to RAM):
  - A beat is accepted when wr_valid && wr_ready.
  - On an accepted beat with no drop in progress: mem_ena=1, mem_wea=4'hF, mem_addra=wr_slot*SLOT_BEATS+wr_beat, mem_dina=wr_data.
  - Otherwise mem_ena=0 and mem_wea=0.
- Commit: an accepted wr_last with no drop in progress writes len[wr_slot]=wr_beat+1, advances wr_slot, clears wr_beat and increments pkt_count.
- Oversize handling:
  - Accepted beat at wr_beat==SLOT_BEATS-1 without wr_last: enter DROP.
  - In DROP, beats are still accepted (wr_ready unaffected) but not written.
  - On wr_last in DROP: exit DROP, drop_cnt++ (saturating at 16'hFFFF), wr_slot unchanged, wr_beat=0.
  - A packet of exactly SLOT_BEATS beats is accepted normally.
- Full: pkt_count==NUM_SLOTS forces wr_ready=0. The in-progress slot is always free, so a packet is never partially blocked by fullness.
- Read FSM states:
  - R_IDLE: if pkt_count>0 && !mem_busy → R_ADDR.
  - R_ADDR: mem_enb=1, mem_addrb=rd_slot*SLOT_BEATS+rd_beat → R_WAIT; wait counter = RD_LAT.
  - R_WAIT: counts down. At 0, register mem_doutb into rd_data, set rd_valid=1, rd_last=(rd_beat==len[rd_slot]-1) → R_HOLD.
  - R_HOLD: rd_valid and rd_data are held stable until rd_ready.
    - On handshake with !rd_last: rd_beat++ → R_ADDR (or R_IDLE if mem_busy).
    - On handshake with rd_last: rd_slot advances, rd_beat=0, pkt_count-- → R_IDLE.
  - Throughput: one beat per RD_LAT+2 cycles.
- Simultaneous commit and last-beat pop in the same cycle: pkt_count unchanged.
- mem_busy: suppresses new writes (wr_ready=0) and the R_IDLE/R_HOLD→R_ADDR issue. A read already issued completes.
- Registered output reset values: rd_valid=0, rd_data=0, rd_last=0, mem_enb=0, mem_addrb=0, pkt_count=0, drop_cnt=0.

Test Plan:
- Reset, write a 3-beat packet 0xA0,0xA1,0xA2 (last on 0xA2) → mem_addra 0,1,2, pkt_count=1; read → rd_data A0,A1,A2 with rd_last only on A2, pkt_count=0.
- Write 17 beats with last on beat 17, SLOT_BEATS=16 → only beats 0..15 written, drop_cnt=1, pkt_count=0. A following 1-beat packet lands at address 0.
- Fill 100 one-beat packets with rd_ready=0 → wr_ready=0 at pkt_count=100. Drain one → wr_ready=1; next write goes to slot 0 at address 0 (wrap).
- Hold rd_ready=0 for 10 cycles in R_HOLD → rd_data and rd_valid stable. Commit a packet in the same cycle as a last-beat pop → pkt_count unchanged.
- Assert mem_busy=1 for 5 cycles mid-stream → wr_ready=0, mem_enb not pulsed. Resumes with no lost or duplicated beats.
- Pull reset low mid-packet (beat 2 of 5) → all outputs 0 asynchronously. After release, pkt_count=0 and the next packet starts at address 0.
